branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage predictor on the branch path; the decode-stage comparator is the resolving end of the same interface.
- Per cycle: looks up fetch PC in a direct-mapped table of tagged 2-bit saturating counters plus targets; drives predicted taken/target to PC select.
- One cycle later, receives decode resolution (taken flag, target), trains the table, and raises mispredict/redirect when the prediction was wrong.

Parameters:
- ENTRIES, 64, table depth; power of two, 4..1024.
- IDX_W, $clog2(ENTRIES), index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pc_f  in  32  fetch PC, word aligned.
- stall_f  in  1  F/D register hold.
- flush_d  in  1  clears F/D register contents.
- pred_taken_f  out  1  predict taken for pc_f.
- pred_target_f  out  32  predicted target; 0 when pred_taken_f=0.
- upd_valid  in  1  decode-stage instruction is a resolved conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM).
- upd_pc  in  32  PC of that branch.
- upd_taken  in  1  resolved outcome from the decode comparator.
- upd_target  in  32  resolved target.
- mispredict  out  1  prediction for upd_pc was wrong; combinational.
- redirect_pc  out  32  corrected fetch PC: upd_taken ? upd_target : upd_pc+8.

Behaviour:
- Index = pc[IDX_W+1:2].
- Tag = pc[31:IDX_W+2].
- Entry fields: valid, tag, ctr[1:0], target[31:0].
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is combinational from table registers.
- hit = valid && tag match.
- pred_taken_f = hit && ctr[1].
- Lookup in the same cycle as a write to the same index returns the pre-write (old) entry.
- F/D register {pd_taken, pd_target}: on a clk edge with !stall_f, loads pred_taken_f and pred_target_f.
  - flush_d has priority over stall_f and loads 0/0.
- mispredict = upd_valid && (upd_taken != pd_taken || (upd_taken && upd_target != pd_target)).
  - Forced 0 when upd_valid=0.
  - redirect_pc is valid only while mispredict=1; the consumer ignores it otherwise.
  - upd_pc+8 wraps modulo 2^32.
- Update happens on a clk edge with upd_valid=1; it is independent of stall_f.
  - Hit: ctr increments toward 11 if taken, decrements toward 00 if not, saturating. Target is written only if taken.
  - Miss and taken: allocate. valid=1, tag, target=upd_target, ctr=WT; overwrites any victim.
  - Miss and not taken: no write.
- Reset:
  - All valid=0, ctr=WNT, target=0; pd_taken=0, pd_target=0.
  - Outputs therefore reset to pred_taken_f=0, pred_target_f=0, mispredict=0.
  - Reset mid-operation discards all history immediately, with no clock needed.
- No X propagation: uninitialised fields are never read, because valid gates them.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Each increments on a clk edge where upd_valid=1 (respectively mispredict=1).
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared header/package bp_defs: counter encodings (BP_SNT, BP_WNT, BP_WT, BP_ST), BP_DEFAULT_ENTRIES, and the PC+8 delay-slot offset constant.
- One sub-module, bp_sat_ctr2: combinational 2-bit saturating next-state (ctr, taken -> ctr_next).
  - Instantiated once on the update path.

Test Plan:
- Cold start: rst pulse, pc_f=0x00400010 -> pred_taken_f=0. Next cycle upd_valid=1, upd_pc=0x00400010, upd_taken=1, upd_target=0x00400100 -> mispredict=1, redirect_pc=0x00400100. Following lookup of 0x00400010 -> pred_taken_f=1, pred_target_f=0x00400100 (ctr=WT).
- Saturation: taken 3x then not-taken 1x on same PC -> ctr 10→11→11→10; prediction remains taken. Two more not-taken -> ctr=00 and pred_taken_f=0; first not-taken after ST -> mispredict=1, redirect_pc=upd_pc+8.
- Alias: ENTRIES=64; train 0x00400010 taken, then 0x00400110 (same index, different tag). Lookup 0x00400110 before its update -> miss (0). Its taken update replaces the entry. Lookup 0x00400010 -> miss.
- Not-taken miss: upd_taken=0 on an untrained PC -> mispredict=0, no allocation, later lookup still 0.
- Stall/flush: stall_f=1 across an edge holds pd_taken. flush_d=1 with stall_f=1 -> pd_taken=0, so a taken branch resolved next reports mispredict=1. Same-index update+lookup in one cycle -> lookup reflects the old entry.
- Async reset: assert rst between edges after training -> outputs 0 immediately; retrained PC behaves as cold. With BP_STATS_EN, 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2, both 0 after rst.

Source files
------------

// File: rtl/bp_defs.sv
// bp_defs: shared definitions for the fetch-stage branch predictor.
//   - 2-bit saturating counter encodings (BP_SNT..BP_ST)
//   - default table depth
//   - delay-slot fall-through offset used to build the redirect PC
package bp_defs;

  localparam logic [1:0] BP_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] BP_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] BP_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] BP_ST  = 2'b11;  // strongly taken

  localparam int BP_DEFAULT_ENTRIES = 64;

  // Fall-through skips the branch and its delay slot.
  localparam logic [31:0] BP_DS_OFFSET = 32'd8;

endpackage

// File: rtl/bp_sat_ctr2.sv
// bp_sat_ctr2: combinational next-state for a 2-bit saturating counter.
// Ports:
//   ctr      in  [1:0]  current counter value
//   taken    in         resolved branch outcome
//   ctr_next out [1:0]  counter moved one step toward ST (taken) or SNT
module bp_sat_ctr2
  import bp_defs::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped table of tagged 2-bit counters + targets.
// Fetch side looks up pc_f combinationally; the prediction is carried in the
// F/D register and compared against the decode-stage resolution one cycle
// later, which also trains the table.
// Ports:
//   clk, rst            clock, async active-high reset
//   pc_f                fetch PC
//   stall_f, flush_d    F/D register hold / clear (flush wins)
//   pred_taken_f        predicted taken for pc_f
//   pred_target_f       predicted target (0 when not predicted taken)
//   upd_valid/pc/taken/target  decode resolution of a conditional branch
//   mispredict          resolution disagrees with the carried prediction
//   redirect_pc         corrected fetch PC, meaningful while mispredict=1
// Optional: define BP_STATS_EN to add stat_branches / stat_mispredicts.
module branch_predictor
  import bp_defs::*;
#(
  parameter int ENTRIES = BP_DEFAULT_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic        stall_f,
  input  logic        flush_d,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  // Word alignment makes the low PC bits meaningless here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[1:0], upd_pc[1:0]};

  // Fetch lookup (reads current table contents, so same-cycle writes are not seen)
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f         = pc_f[IDX_W+1:2];
  assign tag_f         = pc_f[31:IDX_W+2];
  assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f  = hit_f && ctr_q[idx_f][1];
  assign pred_target_f = pred_taken_f ? target_q[idx_f] : 32'd0;

  // F/D register carrying the prediction to decode
  logic        pd_taken_q, pd_taken_d;
  logic [31:0] pd_target_q, pd_target_d;

  always_comb begin
    pd_taken_d  = pd_taken_q;
    pd_target_d = pd_target_q;
    if (flush_d) begin
      pd_taken_d  = 1'b0;
      pd_target_d = 32'd0;
    end else if (!stall_f) begin
      pd_taken_d  = pred_taken_f;
      pd_target_d = pred_target_f;
    end
  end

  assign mispredict  = upd_valid &&
                       ((upd_taken != pd_taken_q) ||
                        (upd_taken && (upd_target != pd_target_q)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + BP_DS_OFFSET);

  // Training path
  logic [IDX_W-1:0] idx_u;
  logic [TAG_W-1:0] tag_u;
  logic             hit_u;
  logic [1:0]       ctr_next_u;
  logic             ent_we_d;
  logic [1:0]       ent_ctr_d;
  logic [31:0]      ent_target_d;

  assign idx_u = upd_pc[IDX_W+1:2];
  assign tag_u = upd_pc[31:IDX_W+2];
  assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

  bp_sat_ctr2 u_sat_ctr (
    .ctr      (ctr_q[idx_u]),
    .taken    (upd_taken),
    .ctr_next (ctr_next_u)
  );

  always_comb begin
    ent_we_d     = 1'b0;
    ent_ctr_d    = ctr_next_u;
    ent_target_d = target_q[idx_u];
    if (upd_valid) begin
      if (hit_u) begin
        ent_we_d = 1'b1;
        if (upd_taken) ent_target_d = upd_target;
      end else if (upd_taken) begin
        // Allocate on a taken miss, evicting whatever held the slot.
        ent_we_d     = 1'b1;
        ent_ctr_d    = BP_WT;
        ent_target_d = upd_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= BP_WNT;
        target_q[i] <= 32'd0;
      end
      pd_taken_q  <= 1'b0;
      pd_target_q <= 32'd0;
    end else begin
      if (ent_we_d) begin
        valid_q[idx_u]  <= 1'b1;
        tag_q[idx_u]    <= tag_u;
        ctr_q[idx_u]    <= ent_ctr_d;
        target_q[idx_u] <= ent_target_d;
      end
      pd_taken_q  <= pd_taken_d;
      pd_target_q <= pd_target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, upd_valid};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=64, index = pc[7:2]).
// Inputs change 1 time unit after a rising edge; outputs are checked
// before the next rising edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        stall_f, flush_d;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_f          (pc_f),
    .stall_f       (stall_f),
    .flush_d       (flush_d),
    .pred_taken_f  (pred_taken_f),
    .pred_target_f (pred_target_f),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tg;
    #1;
  endtask

  task automatic noupd();
    upd_valid  = 1'b0;
    upd_taken  = 1'b0;
    upd_target = 32'd0;
    #1;
  endtask

  task automatic chk_pred(input string tag, input logic tk, input logic [31:0] tg);
    chk_val({tag, "_taken"}, {31'd0, pred_taken_f}, {31'd0, tk});
    chk_val({tag, "_target"}, pred_target_f, tg);
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'd0; stall_f = 1'b0; flush_d = 1'b0;
    upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_pred("rst", 1'b0, 32'd0);
    chk_val("rst_mp", {31'd0, mispredict}, 32'd0);

    // Cold start
    pc_f = 32'h0040_0010; #1;
    chk_val("cold_pred", {31'd0, pred_taken_f}, 32'd0);
    tick();
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    chk_val("cold_mp", {31'd0, mispredict}, 32'd1);
    chk_val("cold_redir", redirect_pc, 32'h0040_0100);
    chk_val("cold_same_cyc_old", {31'd0, pred_taken_f}, 32'd0);
    tick();
    noupd();
    chk_pred("cold_hit", 1'b1, 32'h0040_0100);
    tick();

    // Saturation: WT -> ST -> ST -> WT -> WNT -> SNT -> SNT -> WNT
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    chk_val("sat_t1_mp", {31'd0, mispredict}, 32'd0);
    tick();
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    chk_val("sat_t2_mp", {31'd0, mispredict}, 32'd0);
    chk_pred("sat_st", 1'b1, 32'h0040_0100);
    tick();
    upd(32'h0040_0010, 1'b0, 32'd0);
    chk_val("sat_nt1_mp", {31'd0, mispredict}, 32'd1);
    chk_val("sat_nt1_redir", redirect_pc, 32'h0040_0018);
    tick();
    chk_pred("sat_wt", 1'b1, 32'h0040_0100);
    chk_val("sat_nt2_mp", {31'd0, mispredict}, 32'd1);
    tick();
    chk_val("sat_wnt_pred", {31'd0, pred_taken_f}, 32'd0);
    chk_val("sat_nt3_mp", {31'd0, mispredict}, 32'd1);
    tick();
    chk_val("sat_snt_pred", {31'd0, pred_taken_f}, 32'd0);
    chk_val("sat_nt4_mp", {31'd0, mispredict}, 32'd0);
    tick();
    upd(32'h0040_0010, 1'b1, 32'h0040_0500);
    chk_val("sat_floor_mp", {31'd0, mispredict}, 32'd1);
    chk_val("sat_floor_redir", redirect_pc, 32'h0040_0500);
    tick();
    noupd();
    chk_val("sat_floor_pred", {31'd0, pred_taken_f}, 32'd0);

    // Alias: 0x00400010 and 0x00400110 share index 4
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    tick();
    noupd();
    chk_pred("alias_trained", 1'b1, 32'h0040_0100);
    pc_f = 32'h0040_0110; #1;
    chk_pred("alias_miss", 1'b0, 32'd0);
    upd(32'h0040_0110, 1'b1, 32'h0040_0200);
    tick();
    noupd();
    chk_pred("alias_new", 1'b1, 32'h0040_0200);
    pc_f = 32'h0040_0010; #1;
    chk_val("alias_evicted", {31'd0, pred_taken_f}, 32'd0);

    // Not-taken miss: no allocation
    pc_f = 32'h0040_0020;
    tick();
    upd(32'h0040_0020, 1'b0, 32'h0040_0300);
    chk_val("ntm_mp", {31'd0, mispredict}, 32'd0);
    tick();
    noupd();
    chk_val("ntm_pred", {31'd0, pred_taken_f}, 32'd0);

    // Mispredict gated by upd_valid while pd_taken=1
    pc_f = 32'h0040_0110;
    tick();
    upd_pc = 32'h0040_0110; #1;
    chk_val("gate_mp", {31'd0, mispredict}, 32'd0);

    // Stall holds pd, flush clears it even under stall
    pc_f = 32'h0040_0020; stall_f = 1'b1;
    tick();
    upd(32'h0040_0110, 1'b1, 32'h0040_0200);
    chk_val("stall_hold_mp", {31'd0, mispredict}, 32'd0);
    noupd();
    flush_d = 1'b1;
    tick();
    flush_d = 1'b0; stall_f = 1'b0;
    upd(32'h0040_0110, 1'b1, 32'h0040_0200);
    chk_val("flush_mp", {31'd0, mispredict}, 32'd1);
    chk_val("flush_redir", redirect_pc, 32'h0040_0200);
    noupd();

    // Taken with wrong target
    pc_f = 32'h0040_0110;
    tick();
    upd(32'h0040_0110, 1'b1, 32'h0040_0300);
    chk_val("tgt_mp", {31'd0, mispredict}, 32'd1);
    chk_val("tgt_redir", redirect_pc, 32'h0040_0300);
    noupd();

    // Same-index update and lookup in one cycle: pd captures the old entry
    pc_f = 32'h0040_0010;
    upd(32'h0040_0010, 1'b1, 32'h0040_0400);
    chk_val("sameidx_old", {31'd0, pred_taken_f}, 32'd0);
    tick();
    chk_val("sameidx_mp", {31'd0, mispredict}, 32'd1);
    chk_pred("sameidx_new", 1'b1, 32'h0040_0400);
    tick();
    upd(32'hFFFF_FFFC, 1'b0, 32'd0);
    chk_val("wrap_mp", {31'd0, mispredict}, 32'd1);
    chk_val("wrap_redir", redirect_pc, 32'h0000_0004);
    noupd();

    // Asynchronous reset between edges
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_pred("arst", 1'b0, 32'd0);
    chk_val("arst_mp", {31'd0, mispredict}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_val("arst_cold_pred", {31'd0, pred_taken_f}, 32'd0);

    // Retrain as cold; 5 updates, 2 mispredicts
    upd(32'h0040_0010, 1'b1, 32'h0040_0100);
    chk_val("rt_mp1", {31'd0, mispredict}, 32'd1);
    tick();
    upd(32'h0040_0010, 1'b0, 32'd0);
    chk_pred("rt_wt", 1'b1, 32'h0040_0100);
    chk_val("rt_mp2", {31'd0, mispredict}, 32'd0);
    tick();
    chk_val("rt_wnt_pred", {31'd0, pred_taken_f}, 32'd0);
    chk_val("rt_mp3", {31'd0, mispredict}, 32'd1);
    tick();
    chk_val("rt_mp4", {31'd0, mispredict}, 32'd0);
    tick();
    chk_val("rt_mp5", {31'd0, mispredict}, 32'd0);
    tick();
    noupd();
`ifdef BP_STATS_EN
    chk_val("stat_br", stat_branches, 32'd5);
    chk_val("stat_mp", stat_mispredicts, 32'd2);
    rst = 1'b1; #1;
    chk_val("stat_br_rst", stat_branches, 32'd0);
    chk_val("stat_mp_rst", stat_mispredicts, 32'd0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded expected 0");
    $fatal(1, "timeout");
  end

endmodule
